// File: rtl/rtc_bus_sequencer.sv
// Scans N_REGS registers of a multiplexed-bus RTC, one timed address+data transaction each.
// Define RTC_12H_CONV_EN to convert the hours byte to 12 h BCD when formato_hora=1.
module rtc_bus_sequencer #(
  parameter int         N_REGS    = 10,
  parameter logic [7:0] BASE_ADDR = 8'h21,
  parameter int         T_PHASE   = 4,
  parameter int         HOUR_IDX  = 2,
  localparam int        IDX_W     = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             wr_mode,
  input  logic [7:0]       wr_data,
  input  logic             formato_hora,
  input  logic [7:0]       dato_in,
  output logic [7:0]       dato_out,
  output logic             dato_oe,
  output logic             a_d,
  output logic             cs,
  output logic             rd,
  output logic             wr,
  output logic [IDX_W-1:0] idx,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             am_pm,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_SETUP, S_ADDR_STROBE, S_ADDR_HOLD,
    S_DATA_SETUP, S_DATA_STROBE, S_DATA_HOLD, S_GAP
  } state_t;

  localparam logic [7:0]       T_LAST     = 8'(T_PHASE - 1);
  localparam logic [7:0]       GAP_LAST   = 8'((T_PHASE > 1) ? (T_PHASE - 2) : 0);
  localparam bit               SINGLE_CLK = (T_PHASE == 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_REGS - 1);
  localparam logic [IDX_W-1:0] IDX_HOUR   = IDX_W'(HOUR_IDX);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_mode_q, wr_mode_d;
  logic [7:0]       wr_lat_q, wr_lat_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             done_q, done_d;

  logic phase_end;
  logic gap_final;
  logic last_idx;
  logic is_hour;

  assign phase_end = (cnt_q == T_LAST);
  assign last_idx  = (idx_q == IDX_LAST);
  assign is_hour   = (idx_q == IDX_HOUR);
  // The done cycle stands in for the final GAP clock, so a scan is exactly
  // 7*T_PHASE*N_REGS clocks from start to done and back-to-back scans have no dead cycle.
  assign gap_final = !SINGLE_CLK && (cnt_q == GAP_LAST);

`ifdef RTC_12H_CONV_EN
  logic am_pm_q, am_pm_d;

  // Returns {pm, 12 h BCD hour}; anything that is not a valid 00..23 BCD hour maps to 00 AM.
  function automatic logic [8:0] hour_12h(input logic [7:0] bcd);
    logic valid;
    valid = (bcd[3:0] <= 4'd9) &&
            ((bcd[7:4] < 4'd2) || ((bcd[7:4] == 4'd2) && (bcd[3:0] <= 4'd3)));
    if (!valid)                           return {1'b0, 8'h00};
    else if (bcd == 8'h00)                return {1'b0, 8'h12};
    else if (bcd < 8'h12)                 return {1'b0, bcd};
    else if (bcd == 8'h12)                return {1'b1, 8'h12};
    else if (bcd[7:4] == 4'd1)            return {1'b1, 4'h0, bcd[3:0] - 4'd2};
    else if (bcd[3:0] <= 4'd1)            return {1'b1, 4'h0, bcd[3:0] + 4'd8};
    else                                  return {1'b1, 4'h1, bcd[3:0] - 4'd2};
  endfunction
`else
  logic unused_cfg;
  assign unused_cfg = formato_hora ^ is_hour;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      idx_q      <= '0;
      wr_mode_q  <= 1'b0;
      wr_lat_q   <= 8'h00;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef RTC_12H_CONV_EN
      am_pm_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wr_mode_q  <= wr_mode_d;
      wr_lat_q   <= wr_lat_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
`ifdef RTC_12H_CONV_EN
      am_pm_q    <= am_pm_d;
`endif
    end
  end

  // start/busy handshake: start is a request sampled only while busy=0 (IDLE,
  // including the done cycle); a start seen while busy is dropped, never queued.
  always_comb begin
    state_d    = state_q;
    cnt_d      = phase_end ? 8'd0 : cnt_q + 8'd1;
    idx_d      = idx_q;
    wr_mode_d  = wr_mode_q;
    wr_lat_d   = wr_lat_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
`ifdef RTC_12H_CONV_EN
    am_pm_d    = am_pm_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (start) begin
          state_d   = S_ADDR_SETUP;
          idx_d     = '0;
          wr_mode_d = wr_mode;
        end
      end
      S_ADDR_SETUP:  if (phase_end) state_d = S_ADDR_STROBE;
      S_ADDR_STROBE: if (phase_end) state_d = S_ADDR_HOLD;
      S_ADDR_HOLD: begin
        if (phase_end) begin
          state_d  = S_DATA_SETUP;
          wr_lat_d = wr_data;
        end
      end
      S_DATA_SETUP:  if (phase_end) state_d = S_DATA_STROBE;
      S_DATA_STROBE: begin
        if (phase_end) begin
          state_d = S_DATA_HOLD;
          if (!wr_mode_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = dato_in;
`ifdef RTC_12H_CONV_EN
            if (formato_hora && is_hour) {am_pm_d, rd_data_d} = hour_12h(dato_in);
`endif
          end
        end
      end
      S_DATA_HOLD: begin
        if (phase_end) begin
          if (SINGLE_CLK && last_idx) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (last_idx && gap_final) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (!last_idx && phase_end) begin
          state_d = S_ADDR_SETUP;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d      = 1'b1;
    cs       = 1'b1;
    rd       = 1'b1;
    wr       = 1'b1;
    dato_oe  = 1'b0;
    dato_out = 8'h00;
    case (state_q)
      S_ADDR_SETUP, S_ADDR_STROBE, S_ADDR_HOLD: begin
        a_d      = 1'b0;
        cs       = 1'b0;
        dato_oe  = 1'b1;
        dato_out = BASE_ADDR + 8'(idx_q);
        wr       = (state_q != S_ADDR_STROBE);
      end
      S_DATA_SETUP, S_DATA_STROBE, S_DATA_HOLD: begin
        cs = 1'b0;
        if (wr_mode_q) begin
          dato_oe  = 1'b1;
          dato_out = wr_lat_q;
          wr       = (state_q != S_DATA_STROBE);
        end else begin
          rd = (state_q != S_DATA_STROBE);
        end
      end
      default: ;
    endcase
  end

  assign idx       = idx_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;
`ifdef RTC_12H_CONV_EN
  assign am_pm     = am_pm_q;
`else
  assign am_pm     = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: timeline-based reference model checked every cycle,
// plus directed scans with hand-computed expectations. Honours RTC_12H_CONV_EN.
module tb_rtc_bus_sequencer;

  localparam int         TP   = 2;
  localparam int         NR   = 3;
  localparam int         TL   = 7 * TP * NR;
  localparam int         HOUR = 2;
  localparam logic [7:0] BASE = 8'h21;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start = 1'b0, wr_mode = 1'b0, formato_hora = 1'b0;
  logic [7:0] wr_data = 8'h00, dato_in = 8'h00;
  logic [7:0] dato_out, rd_data;
  logic       dato_oe, a_d, cs, rd, wr, rd_valid, busy, done, am_pm;
  logic [1:0] idx;
  logic [2:0] dbg_state;

  logic       start1 = 1'b0;
  logic [7:0] dato_out1, rd_data1;
  logic       dato_oe1, a_d1, cs1, rd1, wr1, rd_valid1, busy1, done1, am_pm1;
  logic [0:0] idx1;
  logic [2:0] dbg_state1;

  rtc_bus_sequencer #(.N_REGS(NR), .BASE_ADDR(BASE), .T_PHASE(TP), .HOUR_IDX(HOUR)) dut (
    .clk(clk), .reset(reset), .start(start), .wr_mode(wr_mode), .wr_data(wr_data),
    .formato_hora(formato_hora), .dato_in(dato_in), .dato_out(dato_out), .dato_oe(dato_oe),
    .a_d(a_d), .cs(cs), .rd(rd), .wr(wr), .idx(idx), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .am_pm(am_pm), .dbg_state(dbg_state)
  );

  rtc_bus_sequencer #(.N_REGS(1), .BASE_ADDR(BASE), .T_PHASE(1), .HOUR_IDX(0)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .wr_mode(1'b0), .wr_data(8'h00),
    .formato_hora(1'b0), .dato_in(8'h00), .dato_out(dato_out1), .dato_oe(dato_oe1),
    .a_d(a_d1), .cs(cs1), .rd(rd1), .wr(wr1), .idx(idx1), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .busy(busy1), .done(done1), .am_pm(am_pm1), .dbg_state(dbg_state1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

`ifdef RTC_12H_CONV_EN
  function automatic logic [8:0] conv_hour(input logic [7:0] b);
    int hi, lo, h;
    hi = int'(b[7:4]);
    lo = int'(b[3:0]);
    h  = hi * 10 + lo;
    if (lo > 9 || h > 23) return {1'b0, 8'h00};
    if (h == 0)           return {1'b0, 8'h12};
    if (h < 12)           return {1'b0, b};
    if (h == 12)          return {1'b1, 8'h12};
    h = h - 12;
    return {1'b1, 4'(h / 10), 4'(h % 10)};
  endfunction
`endif

  // Reference model: a scan accepted in cycle m_start occupies the following cycles;
  // offset o within the scan gives transaction o/(7*TP) and phase (o%(7*TP))/TP.
  bit         m_act = 1'b0;
  int         m_start = 0;
  bit         m_wr = 1'b0;
  logic [7:0] m_wlat = 8'h00;
  logic [7:0] m_rd = 8'h00;
  logic       m_ampm = 1'b0;

  always @(negedge clk) begin : model_cmp
    int o, tr, ph, sub;
    logic eb, ed, ea_d, ecs, erd, ewr, eoe, erv;
    logic [7:0] edo;
`ifdef RTC_12H_CONV_EN
    logic [8:0] cv;
`endif
    if (!reset) begin
      m_act  = 1'b0;
      m_ampm = 1'b0;
      m_rd   = 8'h00;
    end else begin
      o = 0; tr = 0; ph = 6; sub = 0;
      eb = 0; ed = 0; ea_d = 1; ecs = 1; erd = 1; ewr = 1; eoe = 0; erv = 0; edo = 8'h00;
      if (m_act) begin
        o   = cyc - m_start - 1;
        tr  = o / (7 * TP);
        ph  = (o % (7 * TP)) / TP;
        sub = o % TP;
        eb  = (o < TL - 1);
        ed  = (o == TL - 1);
        if (ph <= 2) begin
          ea_d = 0; ecs = 0; eoe = 1; edo = 8'(BASE + 8'(tr)); ewr = (ph != 1);
        end else if (ph <= 5) begin
          ecs = 0;
          if (m_wr) begin eoe = 1; edo = m_wlat; ewr = (ph != 4); end
          else erd = (ph != 4);
        end
        erv = !m_wr && (ph == 5) && (sub == 0);
      end
      check("busy", busy, eb);
      check("done", done, ed);
      check("a_d", a_d, ea_d);
      check("cs", cs, ecs);
      check("rd", rd, erd);
      check("wr", wr, ewr);
      check("dato_oe", dato_oe, eoe);
      check("rd_valid", rd_valid, erv);
      check("am_pm", am_pm, m_ampm);
      if (eoe) check("dato_out", dato_out, edo);
      if (eb)  check("idx", idx, tr);
      if (erv) check("rd_data", rd_data, m_rd);
      // advance the model with this cycle's inputs
      if (m_act && ph == 2 && sub == TP - 1) m_wlat = wr_data;
      if (m_act && !m_wr && ph == 4 && sub == TP - 1) begin
        m_rd = dato_in;
`ifdef RTC_12H_CONV_EN
        if (formato_hora && tr == HOUR) begin
          cv = conv_hour(dato_in);
          m_rd = cv[7:0];
          m_ampm = cv[8];
        end
`endif
      end
      if (m_act && ed) m_act = 1'b0;
      if (!eb && start) begin
        m_act = 1'b1; m_start = cyc; m_wr = wr_mode;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_read55();
    int done_k = 0, n_done = 0;
    int rv_k[$];
    formato_hora = 1'b0; wr_mode = 1'b0; dato_in = 8'h55;
    for (int k = 0; k <= 60; k++) begin
      start = (k == 0) || (k == 23);
      @(negedge clk);
      if (k == 1) begin
        check("read_first_busy", busy, 1);
        check("read_first_idx", idx, 0);
      end
      if (k >= 1 && rd_valid) begin
        rv_k.push_back(k);
        check("read_rd_data_55", rd_data, 8'h55);
      end
      if (k >= 1 && done) begin n_done++; done_k = k; end
      tick();
    end
    start = 1'b0;
    check("read_done_count", n_done, 1);
    check("read_done_offset", done_k, 42);
    check("read_rv_count", rv_k.size(), 3);
    if (rv_k.size() == 3) begin
      check("read_rv_first", rv_k[0], 11);
      check("read_rv_gap0", rv_k[1] - rv_k[0], 14);
      check("read_rv_gap1", rv_k[2] - rv_k[1], 14);
    end
  endtask

  task automatic test_write();
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic prev_wr = 1'b1;
    int rd_low = 0, done_k = 0;
    exp_q = '{8'h21, 8'hA0, 8'h22, 8'hA1, 8'h23, 8'hA2};
    wr_mode = 1'b1;
    for (int k = 0; k <= 45; k++) begin
      start = (k == 0);
      wr_data = 8'hA0 + {6'd0, idx};
      @(negedge clk);
      if (k >= 1) begin
        if (!rd) rd_low++;
        if (!wr && prev_wr) got_q.push_back(dato_out);
        prev_wr = wr;
        if (done) done_k = k;
      end
      tick();
    end
    start = 1'b0; wr_mode = 1'b0;
    check("write_rd_low_cycles", rd_low, 0);
    check("write_done_offset", done_k, 42);
    check("write_strobe_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check("write_strobe_byte", got_q.pop_front(), exp_q.pop_front());
  endtask

  task automatic test_hours();
    logic [7:0] hb[4];
    logic [7:0] er[4];
    logic       ep[4];
    hb = '{8'h00, 8'h13, 8'h20, 8'h12};
`ifdef RTC_12H_CONV_EN
    er = '{8'h12, 8'h01, 8'h08, 8'h12};
    ep = '{1'b0, 1'b1, 1'b1, 1'b1};
`else
    er = '{8'h00, 8'h13, 8'h20, 8'h12};
    ep = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    wr_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      formato_hora = 1'b1; dato_in = hb[i]; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (45) tick();
      check("hours_rd_data", rd_data, er[i]);
      check("hours_am_pm", am_pm, ep[i]);
    end
    formato_hora = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    wr_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    tick();
    start = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (!a_d && !wr) hit = 1'b1;
      else tick();
    end
    check("reset_reached_addr_strobe", hit, 1);
    if (hit) begin
      #1 reset = 1'b0;
      #1;
      check("reset_async_wr", wr, 1);
      check("reset_async_cs", cs, 1);
      check("reset_async_a_d", a_d, 1);
      check("reset_async_oe", dato_oe, 0);
      check("reset_async_busy", busy, 0);
    end
    tick();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("reset_release_busy", busy, 0);
      tick();
    end
  endtask

  task automatic test_random();
    int h;
    for (int c = 0; c < 1500; c++) begin
      start        = ($urandom_range(0, 7) == 0);
      wr_mode      = 1'($urandom_range(0, 1));
      wr_data      = 8'($urandom);
      formato_hora = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) dato_in = 8'($urandom);
      else begin
        h = $urandom_range(0, 23);
        dato_in = {4'(h / 10), 4'(h % 10)};
      end
      tick();
    end
    start = 1'b0;
    for (int k = 0; k < 100 && busy; k++) tick();
    check("random_drain_idle", busy, 0);
    tick();
  endtask

  task automatic test_b2b();
    bit seen = 1'b0;
    start1 = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (done1) seen = 1'b1;
      else tick();
    end
    check("b2b_first_done", seen, 1);
    for (int k = 1; k <= 21; k++) begin
      tick();
      @(negedge clk);
      check("b2b_cs", cs1, (k % 7 == 0) ? 1 : 0);
      check("b2b_done", done1, (k % 7 == 0) ? 1 : 0);
      check("b2b_rd", rd1, (k % 7 == 5) ? 0 : 1);
      check("b2b_wr", wr1, (k % 7 == 2) ? 0 : 1);
    end
    start1 = 1'b0;
    tick();
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_a_d", a_d, 1);
    check("rst_cs", cs, 1);
    check("rst_rd", rd, 1);
    check("rst_wr", wr, 1);
    check("rst_oe", dato_oe, 0);
    check("rst_dato_out", dato_out, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_am_pm", am_pm, 0);
    check("rst_idx", idx, 0);
    reset = 1'b1;
    tick();
    test_read55();
    test_write();
    test_hours();
    test_reset_mid();
    test_random();
    test_b2b();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded its time limit, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/rtc_bus_sequencer.md
RTC_BUS_SEQUENCER -- requirements
Module: rtc_bus_sequencer

Interface
REQ-001 SHALL have parameter N_REGS, default 10: registers per scan, 1..16.
REQ-002 SHALL have parameter BASE_ADDR, default 8'h21: RTC address of index 0; index i uses BASE_ADDR+i, 8-bit wrap.
REQ-003 SHALL have parameter T_PHASE, default 4: clocks per bus phase, 1..255.
REQ-004 SHALL have parameter HOUR_IDX, default 2: index holding the BCD hours register.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: request one scan of all N_REGS registers.
REQ-008 SHALL have port wr_mode, input, 1: 1 = write scan, 0 = read scan; sampled with start.
REQ-009 SHALL have port wr_data, input, 8: write byte for index idx; sampled on entry to DATA_SETUP.
REQ-010 SHALL have port formato_hora, input, 1: 1 = 12 h display format.
REQ-011 SHALL have port dato_in, input, 8: RTC bus read path.
REQ-012 SHALL have port dato_out, output, 8: RTC bus drive value.
REQ-013 SHALL have port dato_oe, output, 1: 1 = drive bus; the parent owns the tristate.
REQ-014 SHALL have ports a_d, cs, rd, wr, output, 1 each: RTC strobes; cs, rd and wr are active-low; a_d=0 marks address.
REQ-015 SHALL have port idx, output, clog2(N_REGS): current register index.
REQ-016 SHALL have ports rd_data (output, 8) and rd_valid (output, 1): captured byte and its 1-cycle qualifier.
REQ-017 SHALL have ports busy and done, output, 1 each: scan in progress, and 1-cycle end-of-scan pulse.
REQ-018 SHALL have port am_pm, output, 1: 1 = PM for the last hours byte read.

Function
REQ-019 SHALL use these states, each lasting T_PHASE clocks: IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, DATA_SETUP, DATA_STROBE, DATA_HOLD, GAP.
REQ-020 SHALL accept start only in IDLE; the next cycle enters ADDR_SETUP with idx=0 and busy=1. start while busy SHALL be ignored.
REQ-021 SHALL drive the address phases (ADDR_*) with a_d=0, cs=0, dato_oe=1 and dato_out=BASE_ADDR+idx; wr=0 only in ADDR_STROBE.
REQ-022 SHALL drive the data phases (DATA_*) with a_d=1 and cs=0.
REQ-023 In a write scan, SHALL hold dato_oe=1 and dato_out=wr_data latched on DATA_SETUP entry; wr=0 only in DATA_STROBE.
REQ-024 In a read scan, SHALL hold dato_oe=0 with rd=0 only in DATA_STROBE.
REQ-025 In a read scan, SHALL capture dato_in on the last DATA_STROBE clock and assert rd_valid with rd_data on the next cycle.
REQ-026 SHALL idle GAP and IDLE at a_d=1, cs=1, rd=1, wr=1, dato_oe=0; rd and wr SHALL never be low together.
REQ-027 After GAP, SHALL increment idx and return to ADDR_SETUP if idx<N_REGS-1; otherwise enter IDLE with done=1 for one cycle and busy=0 in that same cycle.
REQ-028 SHALL take 7*T_PHASE clocks per transaction and 7*T_PHASE*N_REGS clocks from the start cycle to the done cycle, exclusive.
REQ-029 SHALL implement the phase counter as 8 bits; T_PHASE=1 gives single-clock phases with no dead cycles.
REQ-030 SHALL allow start on the same cycle as done (IDLE) and begin the new scan on the next cycle.

Reset
REQ-031 While reset=0, SHALL force IDLE, idx=0, a_d=cs=rd=wr=1, dato_oe=0, dato_out=0, rd_data=0, rd_valid=busy=done=am_pm=0, asynchronously.
REQ-032 Reset asserted mid-transaction SHALL release all strobes immediately; no partial transaction resumes after release.

Configuration
REQ-033 With RTC_12H_CONV_EN defined, on a read of HOUR_IDX with formato_hora=1, rd_data SHALL be 12 h BCD: 00->12 AM, 01..11 unchanged AM, 12->12 PM, 13..23 -> hour-12 PM, invalid BCD -> 00 AM; am_pm SHALL update with rd_valid.
REQ-034 With RTC_12H_CONV_EN defined and formato_hora=0, or with the macro undefined, rd_data SHALL equal the raw byte; undefined SHALL also tie am_pm to 0 and ignore formato_hora.

Verification
REQ-035 N_REGS=3, T_PHASE=2, read scan, dato_in=8'h55 -> three rd_valid pulses each 14 clocks apart, rd_data=8'h55; done exactly 42 clocks after the start cycle.
REQ-036 Write scan with wr_data=8'hA0+idx -> dato_out = 8'h21, 8'hA0, 8'h22, 8'hA1, 8'h23, 8'hA2 during wr=0 strobes; rd stays 1 throughout.
REQ-037 RTC_12H_CONV_EN defined, formato_hora=1, hours byte 8'h00 / 8'h13 / 8'h20 / 8'h12 -> rd_data 8'h12/8'h01/8'h08/8'h12, am_pm 0/1/1/1.
REQ-038 start pulsed during DATA_STROBE of idx 1 -> ignored; single done; total clocks unchanged.
REQ-039 reset=0 in the middle of ADDR_STROBE -> wr=1 and cs=1 in the same cycle without a clock edge; after release, busy=0 until the next start.
REQ-040 T_PHASE=1, N_REGS=1, start repeated in each done cycle -> back-to-back scans of 7 clocks; cs is high for exactly the GAP clock.
